// File: rtl/spart_pkg.sv
// ---------------------------------------------------------------------------
// spart_pkg
// Definitions shared by the SPART receive and transmit sides.
//   OVERSAMPLE_DEFAULT : baud_en ticks per serial bit period
//   spart_state_t      : encoding of the serial framing FSM states
// No ports; import with "import spart_pkg::*;".
// ---------------------------------------------------------------------------
package spart_pkg;

    localparam int OVERSAMPLE_DEFAULT = 16;

    // The encodings are kept fixed so that existing software and waveform
    // decoders that know the raw state values keep working.
    typedef logic [2:0] spart_state_t;

    localparam spart_state_t IDLE    = 3'd0;
    localparam spart_state_t START   = 3'd1;
    localparam spart_state_t DATA    = 3'd2;
    localparam spart_state_t STOP    = 3'd3;
    localparam spart_state_t WAIT_HI = 3'd4;

endpackage

// File: rtl/spart_sync.sv
// ---------------------------------------------------------------------------
// spart_sync
// Two-flop synchronizer for a single asynchronous input.
//   clk : system clock
//   rst : synchronous active-high reset, both flops reset to 1 (line idle)
//   d   : asynchronous input
//   q   : synchronized output, two clk of latency
// ---------------------------------------------------------------------------
module spart_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Both stages reset high so an idle serial line never looks like a start
    // bit while coming out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spart_rx.sv
// ---------------------------------------------------------------------------
// spart_rx
// Oversampling 8N1 serial receiver with a single receive holding register.
//   OVERSAMPLE : baud_en ticks per bit, even, 8..32
//   clk        : system clock
//   rst        : synchronous active-high reset
//   baud_en    : one-clk oversample tick
//   rxd        : asynchronous serial input, idle high, LSB first
//   clr_rda    : one-clk pulse when the holding register is read
//   rx_data    : receive holding register
//   rda        : receive data available
//   frm_err    : sticky framing error (stop bit sampled low)
//   ovr_err    : sticky overrun (new byte loaded while rda was still set)
// ---------------------------------------------------------------------------
module spart_rx
    import spart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_en,
    input  logic       rxd,
    input  logic       clr_rda,
    output logic [7:0] rx_data,
    output logic       rda,
    output logic       frm_err,
    output logic       ovr_err
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] MID_TICK  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] LAST_TICK = CW'(OVERSAMPLE - 1);

    logic          rxd_s;
    spart_state_t  state;
    logic [CW-1:0] tick_cnt;
    logic [CW-1:0] next_tick;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          stop_sample;
    logic          load;
    logic          frame_bad;

    spart_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (rxd_s)
    );

    assign next_tick   = (tick_cnt == LAST_TICK) ? '0 : tick_cnt + 1'b1;

    // The stop bit is judged on the tick that ends its count; a good stop
    // bit loads the holding register on that same edge.
    assign stop_sample = (state == STOP) && baud_en && (tick_cnt == LAST_TICK);
    assign load        = stop_sample && rxd_s;
    assign frame_bad   = stop_sample && !rxd_s;

    // Framing FSM. Everything here moves only on baud_en, so the FSM, the
    // tick counter and the shift register freeze between oversample ticks.
    // Entering DATA at mid start bit means each full OVERSAMPLE count later
    // lands in the middle of the next bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
        end else if (baud_en) begin
            case (state)
                IDLE: begin
                    if (!rxd_s) begin
                        state    <= START;
                        tick_cnt <= '0;
                    end
                end
                START: begin
                    if (tick_cnt == MID_TICK) begin
                        tick_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= rxd_s ? IDLE : DATA;
                    end else begin
                        tick_cnt <= next_tick;
                    end
                end
                DATA: begin
                    tick_cnt <= next_tick;
                    if (tick_cnt == LAST_TICK) begin
                        shift[bit_idx] <= rxd_s;
                        bit_idx        <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end
                end
                STOP: begin
                    tick_cnt <= next_tick;
                    if (tick_cnt == LAST_TICK) begin
                        state <= rxd_s ? IDLE : WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    // A held-low line (break) must not be mistaken for the
                    // start bit of a new frame.
                    if (rxd_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    tick_cnt <= '0;
                end
            endcase
        end
    end

    // Holding register and status flags. A load beats a simultaneous read:
    // rda stays set and ovr_err keeps its value, while frm_err is still
    // cleared by the read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data <= 8'h00;
            rda     <= 1'b0;
            frm_err <= 1'b0;
            ovr_err <= 1'b0;
        end else begin
            if (load) begin
                rx_data <= shift;
            end

            if (load) begin
                rda <= 1'b1;
            end else if (clr_rda) begin
                rda <= 1'b0;
            end

            if (frame_bad) begin
                frm_err <= 1'b1;
            end else if (clr_rda) begin
                frm_err <= 1'b0;
            end

            if (clr_rda) begin
                if (!load) begin
                    ovr_err <= 1'b0;
                end
            end else if (load && rda) begin
                ovr_err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/spart_rx.md
SPART_RX -- requirements
Module: spart_rx

Interface
REQ-001 Parameter OVERSAMPLE, default 16, sets the number of baud_en ticks per bit; it SHALL be an even value from 8 to 32.
REQ-002 clk  input  1  system clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 baud_en  input  1  oversample tick, one clk wide, OVERSAMPLE ticks per bit period.
REQ-005 rxd  input  1  asynchronous serial line, idle high, 8N1 framing, LSB first.
REQ-006 clr_rda  input  1  one-cycle pulse from the bus interface when the receive buffer is read.
REQ-007 rx_data  output  8  receive holding register.
REQ-008 rda  output  1  receive data available.
REQ-009 frm_err  output  1  sticky framing-error flag.
REQ-010 ovr_err  output  1  sticky overrun flag.

Function
REQ-011 rxd SHALL pass through a 2-flop synchronizer (rxd_s) before any use, adding 2 clk of latency.
REQ-012 The FSM SHALL have the states IDLE, START, DATA, STOP and WAIT_HI, and SHALL advance its tick counter only on baud_en.
REQ-013 IDLE: when rxd_s==0, the FSM SHALL go to START with the tick counter cleared.
REQ-014 START: at tick OVERSAMPLE/2 (mid start bit), rxd_s==0 SHALL lead to DATA with the counter cleared; rxd_s==1 SHALL be treated as a glitch and SHALL return to IDLE.
REQ-015 DATA: every OVERSAMPLE ticks, rxd_s SHALL be shifted into bit position 0..7 in order, LSB first; after bit 7 the FSM SHALL go to STOP.
REQ-016 STOP: after OVERSAMPLE ticks, rxd_s==1 SHALL load the shift register into rx_data and go to IDLE; rxd_s==0 SHALL set frm_err, SHALL leave rx_data unchanged and SHALL go to WAIT_HI.
REQ-017 WAIT_HI: the FSM SHALL remain in WAIT_HI until rxd_s==1 and then go to IDLE, so that a break condition never retriggers a frame.
REQ-018 rda SHALL be 1 on the clk edge that loads rx_data, one cycle after the stop-sample tick.
REQ-019 When a load occurs while rda==1 already, ovr_err SHALL be set and rx_data SHALL be overwritten with the new byte.
REQ-020 clr_rda SHALL clear rda, frm_err and ovr_err on the next edge.
REQ-021 When clr_rda and a load occur in the same cycle, the load SHALL win: rda=1, ovr_err unchanged, frm_err cleared.
REQ-022 While baud_en==0, the FSM, counter and shift register SHALL hold; the synchronizer SHALL keep sampling.
REQ-023 The tick counter SHALL be $clog2(OVERSAMPLE) bits wide and SHALL wrap to 0 at OVERSAMPLE-1.

Reset
REQ-024 rst SHALL force state=IDLE, counter=0, shift=0, rx_data=8'h00, rda=0, frm_err=0, ovr_err=0 and both synchronizer flops=1.
REQ-025 rst asserted mid-frame SHALL abort the frame with no rda or error flag raised, and rst SHALL take priority over clr_rda and baud_en.

Structure
REQ-026 The state enumeration and the OVERSAMPLE default SHALL reside in shared package spart_pkg, which is shared with the transmit side.
REQ-027 The synchronizer SHALL be a separate sub-module spart_sync (width-1, 2 flops, reset value 1); all other logic SHALL be in spart_rx.

Verification
REQ-028 With baud_en tied high and OVERSAMPLE=16, a frame for 0x55 (16 clk per bit) SHALL give rx_data=8'h55 and rda=1 exactly 2+8+8*16+16+1 clk after the rxd falling edge.
REQ-029 An rxd low pulse of 4 clk in IDLE SHALL return the FSM to IDLE, with rda=0 and frm_err=0.
REQ-030 A frame for 0xA3 with its stop bit held low SHALL give frm_err=1, leave rx_data unchanged, and keep the FSM in WAIT_HI until rxd returns high.
REQ-031 Frames 0x12 then 0x34 with no clr_rda SHALL give rx_data=8'h34, rda=1 and ovr_err=1; a subsequent clr_rda SHALL clear all three flags.
REQ-032 clr_rda asserted on the load cycle of 0x7E SHALL leave rda=1 and ovr_err=0.
REQ-033 rst during bit 4 of a frame, followed by a clean 0xC0 frame, SHALL give rx_data=8'hC0 with no error flag set.
